// File: rtl/frame_streamer_pkg.sv
// Shared types and helpers for the sample-frame streamer.
// Holds the FSM encoding, the overrun saturation value and the sample format conversion.
package frame_streamer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [7:0] OVERRUN_SAT = 8'hFF;

    // Offset binary to two's complement is a flip of the sample MSB; w is the sample width (<= 64).
    function automatic logic [63:0] offset_to_twos(input logic [63:0] d, input int w);
        return d ^ (64'd1 << (w - 1));
    endfunction

endpackage

// File: rtl/stream_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// Latency: a pushed word is visible on dout_o the cycle after the push.
// Backpressure: the producer must respect count_o; pushes into a full FIFO are dropped and flagged.
module stream_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      cnt_q;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i & ~full;
    assign do_pop  = pop_i & ~empty_o;
    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push_i && full));

endmodule

// File: rtl/frame_streamer.sv
// Streams an N-sample window from the circular sample BRAM, oldest first, as one AXI-stream frame.
// Latency: start to first tvalid is RD_LAT+2 cycles; then one beat per cycle while tready is high.
// Backpressure: BRAM reads are issued only against free FIFO credits, so tready stalls never lose data.
module frame_streamer
    import frame_streamer_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 12,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   head,
    output logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   data,
    input  logic                start,
    input  logic                continuous,
    input  logic                to_signed,
    output logic [2*DATA_W-1:0] frame_tdata,
    output logic                frame_tvalid,
    input  logic                frame_tready,
    output logic                frame_tlast,
    output logic                busy,
    output logic [7:0]          overrun_cnt,
    output logic [15:0]         frame_cnt
);

    localparam int CW = $clog2(FIFO_DEPTH) + 2;
    localparam int FW = DATA_W + 1;

    state_t                     state_q, state_d;
    logic [ADDR_W-1:0]          base_q, base_d;
    logic [ADDR_W-1:0]          idx_q, idx_d;
    logic [ADDR_W-1:0]          addr_q, addr_d;
    logic                       cont_q, cont_d;
    logic                       sign_q, sign_d;
    logic [7:0]                 ovr_q, ovr_d;
    logic [15:0]                fcnt_q, fcnt_d;
    logic [RD_LAT:0]            vld_q;
    logic [RD_LAT:0]            lst_q;
    logic                       issue;
    logic                       issue_last;
    logic [CW-1:0]              inflight;
    logic                       can_issue;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                       fifo_empty;
    logic [FW-1:0]              fifo_din;
    logic [FW-1:0]              fifo_dout;
    logic [DATA_W-1:0]          sample;
    logic                       pop;
    logic                       last_acc;

    // Stage 0 of the delay line is the registered address; stage RD_LAT lines up with returned data.
    always_comb begin
        inflight = '0;
        for (int i = 0; i <= RD_LAT; i++) begin
            inflight = inflight + CW'(vld_q[i]);
        end
    end

    assign can_issue = (CW'(fifo_count) + inflight) < CW'(FIFO_DEPTH);

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        idx_d      = idx_q;
        addr_d     = addr_q;
        cont_d     = cont_q;
        sign_d     = sign_q;
        fcnt_d     = fcnt_q;
        ovr_d      = ovr_q;
        issue      = 1'b0;
        issue_last = 1'b0;

        if (start && (state_q != IDLE) && (ovr_q != OVERRUN_SAT)) begin
            ovr_d = ovr_q + 8'd1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = READ;
                    base_d  = head;
                    idx_d   = '0;
                    cont_d  = continuous;
                    sign_d  = to_signed;
                end
            end
            READ: begin
                if (can_issue) begin
                    issue      = 1'b1;
                    issue_last = &idx_q;
                    addr_d     = base_q + idx_q;
                    idx_d      = idx_q + 1'b1;
                    if (&idx_q) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (last_acc) begin
                    fcnt_d = fcnt_q + 16'd1;
                    // Restart needs continuous set both at this frame's start and now, so a clear lands after this frame.
                    if (cont_q && continuous) begin
                        state_d = READ;
                        base_d  = head;
                        idx_d   = '0;
                        cont_d  = continuous;
                        sign_d  = to_signed;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            base_q  <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            cont_q  <= 1'b0;
            sign_q  <= 1'b0;
            fcnt_q  <= '0;
            ovr_q   <= '0;
            vld_q   <= '0;
            lst_q   <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            cont_q  <= cont_d;
            sign_q  <= sign_d;
            fcnt_q  <= fcnt_d;
            ovr_q   <= ovr_d;
            vld_q   <= {vld_q[RD_LAT-1:0], issue};
            lst_q   <= {lst_q[RD_LAT-1:0], issue_last};
        end
    end

    assign sample   = sign_q ? DATA_W'(offset_to_twos(64'(data), DATA_W)) : data;
    assign fifo_din = {lst_q[RD_LAT], sample};

    stream_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset_n),
        .push_i  (vld_q[RD_LAT]),
        .din_i   (fifo_din),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign frame_tvalid = ~fifo_empty;
    assign frame_tlast  = fifo_dout[DATA_W] & ~fifo_empty;
    assign frame_tdata  = {{DATA_W{1'b0}}, fifo_dout[DATA_W-1:0]};
    assign pop          = frame_tvalid & frame_tready;
    assign last_acc     = pop & frame_tlast;
    assign busy         = (state_q != IDLE);
    assign addr         = addr_q;
    assign overrun_cnt  = ovr_q;
    assign frame_cnt    = fcnt_q;

endmodule

// File: tb/tb_frame_streamer.sv
// Scoreboard bench for frame_streamer with a 16-point window and a 2-cycle BRAM model.
module tb_frame_streamer;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int RL = 2;
    localparam int FD = 8;
    localparam int N  = 16;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [AW-1:0]   head;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   data;
    logic            start;
    logic            continuous;
    logic            to_signed;
    logic [2*DW-1:0] frame_tdata;
    logic            frame_tvalid;
    logic            frame_tready;
    logic            frame_tlast;
    logic            busy;
    logic [7:0]      overrun_cnt;
    logic [15:0]     frame_cnt;

    always #5 clk = ~clk;

    frame_streamer #(
        .DATA_W     (DW),
        .ADDR_W     (AW),
        .RD_LAT     (RL),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .head         (head),
        .addr         (addr),
        .data         (data),
        .start        (start),
        .continuous   (continuous),
        .to_signed    (to_signed),
        .frame_tdata  (frame_tdata),
        .frame_tvalid (frame_tvalid),
        .frame_tready (frame_tready),
        .frame_tlast  (frame_tlast),
        .busy         (busy),
        .overrun_cnt  (overrun_cnt),
        .frame_cnt    (frame_cnt)
    );

    // BRAM model: data valid two cycles after addr.
    logic [DW-1:0] mem [N];
    logic [AW-1:0] a1, a2;
    always @(posedge clk) begin
        a1 <= addr;
        a2 <= a1;
    end
    assign data = mem[a2];

    logic [2*DW:0] expq[$];
    int  checks = 0;
    int  errors = 0;
    int  exp_frames = 0;
    int  beat_idx = 0;
    int  gap = 0;
    int  max_cnt = 0;
    bit  cont_act = 0;
    bit  gap_chk = 0;
    bit  gap_armed = 0;
    bit  stall_prev = 0;
    logic [2*DW:0] stall_val;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [DW-1:0] conv(input logic [DW-1:0] d, input logic s);
        return s ? {~d[DW-1], d[DW-2:0]} : d;
    endfunction

    function automatic void push_frame(input logic [AW-1:0] h, input logic s);
        for (int i = 0; i < N; i++) begin
            logic [AW-1:0] a;
            a = h + AW'(i);
            expq.push_back({(i == N-1), DW'(0), conv(mem[a], s)});
        end
    endfunction

    // Monitor: samples on the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin
        logic [2*DW:0] e;
        if (!reset_n) begin
            beat_idx   = 0;
            exp_frames = 0;
            stall_prev = 0;
            gap_armed  = 0;
        end else begin
            if (int'(dut.u_fifo.count_o) > max_cnt) max_cnt = int'(dut.u_fifo.count_o);
            if (stall_prev) check("stall_hold", {frame_tvalid, frame_tlast, frame_tdata}, {1'b1, stall_val});
            stall_prev = frame_tvalid && !frame_tready;
            stall_val  = {frame_tlast, frame_tdata};
            if (gap_armed && !frame_tvalid) gap++;
            if (frame_tvalid && frame_tready) begin
                if (beat_idx == 0) begin
                    check("frame_cnt_at_sof", frame_cnt, exp_frames);
                    if (gap_armed && gap_chk) check("restart_gap_over4", (gap > 4) ? gap : 0, 0);
                    gap_armed = 0;
                end
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %0h expected no beat", frame_tdata);
                end else begin
                    e = expq.pop_front();
                    check("beat", {frame_tlast, frame_tdata}, e);
                end
                beat_idx++;
                if (frame_tlast) begin
                    beat_idx = 0;
                    exp_frames++;
                    gap = 0;
                    gap_armed = cont_act && continuous;
                    if (cont_act && continuous) push_frame(head, to_signed);
                    else cont_act = 0;
                end
            end
        end
    end

    task automatic do_start(input logic [AW-1:0] h, input bit c, input bit s);
        head       = h;
        continuous = c;
        to_signed  = s;
        start      = 1'b1;
        push_frame(h, s);
        cont_act   = c;
        @(posedge clk); #1;
        start      = 1'b0;
    endtask

    task automatic wait_idle();
        int c = 0;
        while ((expq.size() != 0 || busy) && c < 3000) begin
            @(posedge clk); #1;
            c++;
        end
        if (c >= 3000) begin
            checks++;
            errors++;
            $display("FAIL wait_idle_timeout: got busy=%0b queued=%0d expected idle", busy, expq.size());
        end
    endtask

    initial begin
        int lat;
        int f0;
        int c;
        head = '0; start = 0; continuous = 0; to_signed = 0; frame_tready = 1;
        for (int i = 0; i < N; i++) mem[i] = DW'(i);
        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", frame_tvalid, 0);
        check("rst_tlast", frame_tlast, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun_cnt, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_addr", addr, 0);
        reset_n = 1;
        @(posedge clk); #1;

        // 1: head=5, data=addr, tready=1 -> 5..15,0..4, first tvalid RD_LAT+2 cycles after start
        do_start(4'd5, 0, 0);
        lat = 0;
        while (!frame_tvalid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("first_valid_latency", lat, 4);
        wait_idle();
        check("frame_cnt_t1", frame_cnt, 1);
        check("busy_after_t1", busy, 0);

        // 2: random tready, head wraps (12..15,0..11)
        do_start(4'd12, 0, 0);
        c = 0;
        while ((expq.size() != 0 || busy) && c < 2000) begin
            frame_tready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            c++;
        end
        frame_tready = 1;
        wait_idle();
        check("frame_cnt_t2", frame_cnt, 2);

        // 3: to_signed with 0000/8000/FFFF -> 8000/0000/7FFF
        for (int i = 0; i < N; i++) begin
            case (i % 3)
                0: mem[i] = 16'h0000;
                1: mem[i] = 16'h8000;
                default: mem[i] = 16'hFFFF;
            endcase
        end
        check("conv_0000", conv(mem[0], 1), 16'h8000);
        check("conv_8000", conv(mem[1], 1), 16'h0000);
        check("conv_FFFF", conv(mem[2], 1), 16'h7FFF);
        do_start(4'd0, 0, 1);
        wait_idle();

        // 4: continuous framing with head advancing every 20 cycles; base 15 exercises wrap
        for (int i = 0; i < N; i++) mem[i] = DW'(16'hA000 + i);
        gap_chk = 1;
        f0 = exp_frames;
        do_start(4'd15, 1, 0);
        c = 0;
        while (exp_frames < f0 + 4 && c < 3000) begin
            @(posedge clk); #1;
            c++;
            if (c % 20 == 0) head = head + 1'b1;
        end
        check("cont_frames_reached", (exp_frames >= f0 + 4), 1);
        continuous = 0;
        wait_idle();
        gap_chk = 0;
        check("frame_cnt_t4", frame_cnt, exp_frames);
        check("overrun_before_t5", overrun_cnt, 0);

        // 5: 300 ignored starts while stalled -> overrun saturates at 255
        frame_tready = 0;
        do_start(4'd7, 0, 0);
        repeat (3) begin @(posedge clk); #1; end
        for (int p = 1; p <= 300; p++) begin
            start = 1;
            @(posedge clk); #1;
            start = 0;
            @(posedge clk); #1;
            if (p == 100) check("overrun_100", overrun_cnt, 100);
        end
        check("overrun_sat", overrun_cnt, 255);
        check("busy_stalled", busy, 1);
        frame_tready = 1;
        wait_idle();
        check("overrun_sat_hold", overrun_cnt, 255);

        // 6: reset on beat 7 drops the frame; next start is clean
        do_start(4'd9, 0, 0);
        c = 0;
        while (beat_idx < 7 && c < 200) begin
            @(posedge clk); #1;
            c++;
        end
        check("reached_beat7", (beat_idx >= 7), 1);
        reset_n = 0;
        #1;
        check("midrst_tvalid", frame_tvalid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_overrun", overrun_cnt, 0);
        check("midrst_frame_cnt", frame_cnt, 0);
        expq.delete();
        cont_act = 0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1;
        @(posedge clk); #1;
        do_start(4'd14, 0, 0);
        wait_idle();
        check("frame_cnt_after_rst", frame_cnt, 1);
        check("fifo_count_over_depth", (max_cnt > FD) ? max_cnt : 0, 0);

        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
